// File: rtl/operand_sequencer_pkg.sv
// Shared calculator definitions: FSM state encodings and operand width.
package operand_sequencer_pkg;

  localparam int OPW = 9;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_RES = 2'd2,
    S_BAD = 2'd3
  } seq_state_t;

endpackage

// File: rtl/operand_sequencer_if.sv
// Board-side bundle of the operand sequencer: switches, raw buttons and operand outputs.
interface operand_sequencer_if;
  import operand_sequencer_pkg::*;

  logic [OPW-1:0] sw_num;
  logic           btn_enter;
  logic           btn_clear;
  logic           enter_pulse;
  logic           load_a;
  logic           load_b;
  logic [OPW-1:0] num_a;
  logic [OPW-1:0] num_b;
  logic           result_valid;
  logic [1:0]     state;

  modport master (
    output sw_num, btn_enter, btn_clear,
    input  enter_pulse, load_a, load_b, num_a, num_b, result_valid, state
  );

  modport slave (
    input  sw_num, btn_enter, btn_clear,
    output enter_pulse, load_a, load_b, num_a, num_b, result_valid, state
  );

endinterface

// File: rtl/operand_sequencer_btn_debounce.sv
// Two-flop synchroniser, stable-count debouncer and registered rising-edge pulse
// for one asynchronous push-button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             level_d_reg;
  logic             pulse_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg    <= 2'b00;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      pulse_reg   <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], btn_raw};
      // Any sample agreeing with the accepted level restarts the stability count.
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= ~level_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      level_d_reg <= level_reg;
      pulse_reg   <= level_reg & ~level_d_reg;
    end
  end

  assign btn_level = level_reg;
  assign btn_pulse = pulse_reg;

endmodule

// File: rtl/operand_sequencer.sv
// Calculator front end: debounced ENTER/CLEAR drive a three-step operand FSM
// that captures the switch value into num_a / num_b with load strobes.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input logic               clk,
  input logic               rst,
  operand_sequencer_if.slave bus
);

  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_pulse;
  logic       levels_unused;

  assign btn_raw       = {bus.btn_clear, bus.btn_enter};
  assign levels_unused = &btn_level;

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw[gi]),
      .btn_level(btn_level[gi]),
      .btn_pulse(btn_pulse[gi])
    );
  end

  logic enter_pulse;
  logic clear_pulse;

  assign enter_pulse = btn_pulse[0];
  assign clear_pulse = btn_pulse[1];

  seq_state_t     state_reg;
  logic [OPW-1:0] num_a_reg;
  logic [OPW-1:0] num_b_reg;
  logic           load_a_reg;
  logic           load_b_reg;
  logic           result_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_A;
      num_a_reg        <= '0;
      num_b_reg        <= '0;
      load_a_reg       <= 1'b0;
      load_b_reg       <= 1'b0;
      result_valid_reg <= 1'b0;
    end else begin
      load_a_reg <= 1'b0;
      load_b_reg <= 1'b0;
      // CLEAR wins over a coincident ENTER, which is simply dropped.
      if (clear_pulse) begin
        state_reg        <= S_A;
        num_a_reg        <= '0;
        num_b_reg        <= '0;
        result_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          S_A: begin
            if (enter_pulse) begin
              num_a_reg  <= bus.sw_num;
              load_a_reg <= 1'b1;
              state_reg  <= S_B;
            end
          end
          S_B: begin
            if (enter_pulse) begin
              num_b_reg        <= bus.sw_num;
              load_b_reg       <= 1'b1;
              result_valid_reg <= 1'b1;
              state_reg        <= S_RES;
            end
          end
          S_RES: begin
            if (enter_pulse) begin
              result_valid_reg <= 1'b0;
              state_reg        <= S_A;
            end
          end
          default: begin
            result_valid_reg <= 1'b0;
            state_reg        <= S_A;
          end
        endcase
      end
    end
  end

  assign bus.enter_pulse  = enter_pulse;
  assign bus.load_a       = load_a_reg;
  assign bus.load_b       = load_b_reg;
  assign bus.num_a        = num_a_reg;
  assign bus.num_b        = num_b_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.state        = state_reg;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer with a short debounce window and a
// window-based behavioural model of the button path and operand sequence.
module tb_operand_sequencer;
  import operand_sequencer_pkg::*;

  localparam int DC = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_sequencer_if bus ();

  operand_sequencer #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: a level flips once the synchronised input (raw delayed two edges)
  // has disagreed with it for DC consecutive samples; a pulse follows one edge later.
  bit       hq_e[$];
  bit       hq_c[$];
  bit       m_lvl_e, m_lvl_c, m_rose_e, m_rose_c, m_pe, m_pc, m_la, m_lb;
  int       m_phase;
  logic [8:0] m_a, m_b;

  task automatic model_reset();
    hq_e.delete();
    hq_c.delete();
    for (int i = 0; i < DC + 2; i++) begin
      hq_e.push_back(1'b0);
      hq_c.push_back(1'b0);
    end
    m_lvl_e = 0; m_lvl_c = 0; m_rose_e = 0; m_rose_c = 0;
    m_pe = 0; m_pc = 0; m_la = 0; m_lb = 0;
    m_phase = 0; m_a = '0; m_b = '0;
  endtask

  function automatic bit win_flip(input bit q[$], input bit lvl);
    int n = q.size();
    for (int i = 2; i <= DC + 1; i++)
      if (q[n-i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    bit te, tc;
    if (rst) begin
      model_reset();
    end else begin
      te = win_flip(hq_e, m_lvl_e);
      tc = win_flip(hq_c, m_lvl_c);
      m_la = 0;
      m_lb = 0;
      if (m_pc) begin
        m_phase = 0; m_a = '0; m_b = '0;
      end else if (m_pe) begin
        case (m_phase)
          0:       begin m_a = bus.sw_num; m_la = 1; m_phase = 1; end
          1:       begin m_b = bus.sw_num; m_lb = 1; m_phase = 2; end
          default: m_phase = 0;
        endcase
      end
      m_pe = m_rose_e;
      m_pc = m_rose_c;
      m_rose_e = te & ~m_lvl_e;
      m_rose_c = tc & ~m_lvl_c;
      m_lvl_e = m_lvl_e ^ te;
      m_lvl_c = m_lvl_c ^ tc;
      hq_e.push_back(bus.btn_enter);
      hq_c.push_back(bus.btn_clear);
      if (hq_e.size() > DC + 2) void'(hq_e.pop_front());
      if (hq_c.size() > DC + 2) void'(hq_c.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [23:0] dut_vec();
    return {bus.enter_pulse, bus.load_a, bus.load_b, bus.result_valid, bus.state, bus.num_a, bus.num_b};
  endfunction

  function automatic logic [23:0] exp_vec();
    return {m_pe, m_la, m_lb, (m_phase == 2), 2'(m_phase), m_a, m_b};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.sw_num = 9'($urandom);
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    for (int i = 0; i < 2; i++) step();
    n_checks++;
    if (dut_vec() !== 24'h0 || bus.state !== S_A) begin
      n_fail++;
      $display("FAIL reset: outputs=%h required=000000", dut_vec());
    end
    rst = 1'b0;
    $display("reset: outputs=%h state=%0d", dut_vec(), bus.state);
  endtask

  task automatic test_glitch();
    int pulses = 0;
    for (int i = 0; i < 15; i++) begin
      bus.btn_enter = (i < 3);
      step();
      if (bus.enter_pulse) pulses++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (pulses != 0 || bus.state !== S_A) begin
      n_fail++;
      $display("FAIL glitch_reject: pulses=%0d state=%0d required 0/0", pulses, bus.state);
    end
    $display("glitch: pulses=%0d state=%0d", pulses, bus.state);
  endtask

  task automatic test_capture();
    int pulses = 0;
    int load_at = -1;
    bit saw_b = 0;
    bus.sw_num = 9'h0A5;
    bus.btn_enter = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (i == 21) bus.btn_enter = 1'b0;
      if (i == 12) bus.sw_num = 9'($urandom);
      step();
      if (bus.enter_pulse) pulses++;
      if (bus.load_a && load_at < 0) begin
        load_at = i;
        n_checks++;
        if (bus.num_a !== 9'h0A5 || bus.state !== S_B) begin
          n_fail++;
          $display("FAIL capture_a: num_a=%h state=%0d required 0a5/1", bus.num_a, bus.state);
        end
      end
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL capture_a_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (pulses != 1 || load_at != DC + 4) begin
      n_fail++;
      $display("FAIL capture_a_timing: pulses=%0d load_at=%0d required 1/%0d", pulses, load_at, DC + 4);
    end
    $display("capture a: pulses=%0d load_at=%0d num_a=%h", pulses, load_at, bus.num_a);
    bus.sw_num = 9'h1FF;
    bus.btn_enter = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 21) bus.btn_enter = 1'b0;
      step();
      if (bus.load_b) begin
        saw_b = 1;
        n_checks++;
        if (bus.num_b !== 9'h1FF || bus.state !== S_RES || bus.result_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL capture_b: num_b=%h state=%0d rv=%b required 1ff/2/1", bus.num_b, bus.state, bus.result_valid);
        end
      end
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL capture_b_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (!saw_b) begin
      n_fail++;
      $display("FAIL capture_b_seen: load_b=0 required 1");
    end
    $display("capture b: num_b=%h state=%0d rv=%b", bus.num_b, bus.state, bus.result_valid);
  endtask

  task automatic test_result_enter();
    bus.sw_num = 9'h033;
    bus.btn_enter = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      if (i == 15) bus.btn_enter = 1'b0;
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL result_enter_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (bus.state !== S_A || bus.result_valid !== 1'b0 || bus.num_a !== 9'h0A5) begin
      n_fail++;
      $display("FAIL result_enter: state=%0d rv=%b num_a=%h required 0/0/0a5", bus.state, bus.result_valid, bus.num_a);
    end
    $display("result enter: state=%0d rv=%b num_a=%h", bus.state, bus.result_valid, bus.num_a);
  endtask

  task automatic test_bouncy();
    int loads = 0;
    bus.sw_num = 9'($urandom);
    for (int i = 0; i < 40; i++) begin
      bus.btn_enter = (i < 10) ? ((i / 2) % 2 == 0) : (i < 30);
      step();
      if (bus.load_a) loads++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bouncy_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (loads != 1 || bus.state !== S_B) begin
      n_fail++;
      $display("FAIL bouncy: loads=%0d state=%0d required 1/1", loads, bus.state);
    end
    $display("bouncy: loads=%0d num_a=%h state=%0d", loads, bus.num_a, bus.state);
  endtask

  task automatic test_clear_coincide();
    bit saw_lb = 0;
    bus.sw_num = 9'($urandom);
    bus.btn_enter = 1'b1;
    bus.btn_clear = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      if (i == 15) begin bus.btn_enter = 1'b0; bus.btn_clear = 1'b0; end
      step();
      if (bus.load_b) saw_lb = 1;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL clear_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (saw_lb || bus.state !== S_A || bus.num_a !== 9'h0 || bus.num_b !== 9'h0) begin
      n_fail++;
      $display("FAIL clear_coincide: load_b_seen=%b state=%0d num_a=%h num_b=%h required 0/0/0/0",
               saw_lb, bus.state, bus.num_a, bus.num_b);
    end
    $display("clear+enter: state=%0d num_a=%h num_b=%h", bus.state, bus.num_a, bus.num_b);
  endtask

  task automatic test_reset_mid_debounce();
    int pulses = 0;
    bus.btn_enter = 1'b1;
    for (int i = 0; i < 22; i++) begin
      rst = (i == 4 || i == 5);
      if (i == 4) bus.btn_enter = 1'b0;
      step();
      if (bus.enter_pulse && i > 5) pulses++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rst_release_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL rst_release: pulses=%0d required 0", pulses);
    end
    $display("rst mid-debounce, released: pulses=%0d", pulses);
    pulses = 0;
    bus.btn_enter = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rst = (i == 5 || i == 6);
      if (i == 25) bus.btn_enter = 1'b0;
      step();
      if (bus.enter_pulse && i > 6) pulses++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rst_held_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    rst = 1'b0;
    n_checks++;
    if (pulses != 1 || bus.state !== S_B) begin
      n_fail++;
      $display("FAIL rst_held: pulses=%0d state=%0d required 1/1", pulses, bus.state);
    end
    $display("rst mid-debounce, held: pulses=%0d state=%0d", pulses, bus.state);
  endtask

  task automatic test_random();
    int hold, gap, which;
    for (int op = 0; op < 40; op++) begin
      hold  = int'($urandom_range(1, 3 * DC));
      gap   = int'($urandom_range(1, 3 * DC));
      which = int'($urandom_range(0, 5));
      bus.btn_enter = (which != 0);
      bus.btn_clear = (which == 0 || which == 5);
      for (int i = 0; i < hold + gap; i++) begin
        if (i == hold) begin bus.btn_enter = 1'b0; bus.btn_clear = 1'b0; end
        else if (i < hold && $urandom_range(0, 9) == 0) bus.btn_enter = ~bus.btn_enter;
        bus.sw_num = 9'($urandom);
        step();
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL random op=%0d cyc=%0d got=%h exp=%h", op, cyc, dut_vec(), exp_vec());
        end
      end
      $display("random op=%0d kind=%0d hold=%0d state=%0d num_a=%h num_b=%h",
               op, which, hold, bus.state, bus.num_a, bus.num_b);
    end
  endtask

  initial begin
    bus.sw_num = '0;
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    model_reset();
    test_reset();
    test_glitch();
    test_capture();
    test_result_enter();
    test_bouncy();
    test_clear_coincide();
    test_reset_mid_debounce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
